// File: rtl/rom_streamer_pkg.sv
// ============================================================================
// Module      : rom_streamer_pkg
// Description : Shared FSM state type and FIFO sizing for the ROM streamer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

endpackage

`default_nettype wire

// File: rtl/skid_fifo.sv
// ============================================================================
// Module      : skid_fifo
// Description : Small register FIFO absorbing ROM read data under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_fifo
    import rom_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o,
    output logic [FIFO_CNT_W-1:0] count_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q;
    logic [FIFO_PTR_W-1:0] rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  w_rd;

    // Never pop an empty FIFO, so the count cannot underflow.
    assign w_rd = rd_en_i && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (w_rd) begin
                rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            end
            count_q <= count_q + FIFO_CNT_W'(wr_en_i) - FIFO_CNT_W'(w_rd);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

`default_nettype wire

// File: rtl/rom_streamer.sv
// ============================================================================
// Module      : rom_streamer
// Description : Bursts consecutive words from a registered ROM onto a stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_streamer
    import rom_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tvalid_o,
    output logic                  m_tlast_o,
    input  logic                  m_tready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    state_e                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [ADDR_WIDTH-1:0] len_q,     len_d;
    logic [ADDR_WIDTH-1:0] issued_q,  issued_d;
    logic [ADDR_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic                  inflight_q;
    logic                  done_q,    done_d;

    logic                  w_issue;
    logic                  w_pop;
    logic                  w_last_pop;
    logic                  w_room;
    logic                  w_tvalid;
    logic                  w_tlast;
    logic [2:0]            w_occ;
    logic [FIFO_CNT_W-1:0] w_fifo_cnt;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_fifo_empty;

    skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (inflight_q),
        .wr_data_i (rom_data_i),
        .rd_en_i   (w_pop),
        .rd_data_o (w_fifo_data),
        .empty_o   (w_fifo_empty),
        .count_o   (w_fifo_cnt)
    );

    assign w_tvalid   = !w_fifo_empty;
    assign w_pop      = w_tvalid && m_tready_i;
    assign w_tlast    = w_tvalid && (out_cnt_q == len_q);
    assign w_last_pop = w_pop && w_tlast;

    // Credit check: a pop this cycle frees a slot the new read can land in.
    assign w_occ  = 3'(w_fifo_cnt) + 3'(inflight_q);
    assign w_room = (w_occ < (3'(FIFO_DEPTH) + 3'(w_pop)));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        issued_d  = issued_q;
        out_cnt_d = out_cnt_q;
        done_d    = 1'b0;
        w_issue   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    addr_d    = base_addr_i;
                    len_d     = len_i;
                    issued_d  = '0;
                    out_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (w_room) begin
                    w_issue  = 1'b1;
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + ADDR_WIDTH'(1);
                    if (issued_q == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DRAIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE) begin
            if (w_pop) begin
                out_cnt_d = out_cnt_q + ADDR_WIDTH'(1);
            end
            if (w_last_pop) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= w_issue;
            done_q     <= done_d;
        end
    end

    assign rom_addr_o = addr_q;
    assign m_tdata_o  = w_fifo_data;
    assign m_tvalid_o = w_tvalid;
    assign m_tlast_o  = w_tlast;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_streamer.sv
// ============================================================================
// Module      : tb_rom_streamer
// Description : Directed/randomised bench for rom_streamer with a ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_streamer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [7:0] base_addr_i;
    logic [7:0] len_i;
    logic [7:0] rom_addr_o;
    logic [7:0] rom_data_i = 8'h00;
    logic [7:0] m_tdata_o;
    logic       m_tvalid_o;
    logic       m_tlast_o;
    logic       m_tready_i;
    logic       busy_o;
    logic       done_o;

    logic [7:0] rom_mem [256];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk_i = ~clk_i;

    // One-cycle registered ROM read.
    always @(posedge clk_i) rom_data_i <= rom_mem[rom_addr_o];

    rom_streamer #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .m_tdata_o   (m_tdata_o),
        .m_tvalid_o  (m_tvalid_o),
        .m_tlast_o   (m_tlast_o),
        .m_tready_i  (m_tready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // mode 0: tready high; 1: random tready with a 5-cycle stall;
    // 2: tready high plus a stray start_i mid-burst. abort_at>0 resets after that beat.
    task automatic do_burst(input logic [7:0] base, input logic [7:0] len,
                            input int mode, input int abort_at);
        int         cyc;
        int         beat;
        bit         ready;
        bit         stalled;
        bit         aborted;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [7:0] a;

        start_i     = 1'b1;
        base_addr_i = base;
        len_i       = len;
        step();
        start_i = 1'b0;
        chk("issue_addr", 32'(rom_addr_o), 32'(base));
        chk("busy_run", 32'(busy_o), 32'd1);

        cyc       = 1;
        beat      = 0;
        stalled   = 1'b0;
        aborted   = 1'b0;
        prev_data = 8'h00;
        prev_last = 1'b0;
        while (!aborted && beat <= int'(len) && cyc < 400) begin
            if (mode == 1) ready = (cyc >= 6 && cyc < 11) ? 1'b0 : 1'($urandom_range(0, 1));
            else           ready = 1'b1;
            if (mode == 2) begin
                start_i     = (cyc == 4);
                base_addr_i = 8'h99;
                len_i       = 8'd2;
            end
            m_tready_i = ready;
            chk("no_early_done", 32'(done_o), 32'd0);
            if (stalled) begin
                chk("stall_valid", 32'(m_tvalid_o), 32'd1);
                chk("stall_data", 32'(m_tdata_o), 32'(prev_data));
                chk("stall_last", 32'(m_tlast_o), 32'(prev_last));
            end
            if (m_tvalid_o && ready) begin
                a = base + 8'(beat);
                if (beat == 0 && mode != 1) chk("first_valid_cycle", 32'(cyc), 32'd3);
                chk("beat_data", 32'(m_tdata_o), 32'(rom_mem[a]));
                chk("beat_last", 32'(m_tlast_o), 32'(beat == int'(len)));
                if (beat == int'(len) && mode != 1)
                    chk("last_beat_cycle", 32'(cyc), 32'(3 + int'(len)));
                beat++;
                if (abort_at != 0 && beat == abort_at) aborted = 1'b1;
            end
            stalled   = m_tvalid_o && !ready;
            prev_data = m_tdata_o;
            prev_last = m_tlast_o;
            if (!aborted && beat <= int'(len)) begin
                step();
                cyc++;
            end
        end
        start_i = 1'b0;

        if (aborted) begin
            rst_i = 1'b1;
            step();
            rst_i = 1'b0;
            chk("rst_tvalid", 32'(m_tvalid_o), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_done", 32'(done_o), 32'd0);
            chk("rst_addr", 32'(rom_addr_o), 32'd0);
            repeat (5) begin
                step();
                chk("post_rst_tvalid", 32'(m_tvalid_o), 32'd0);
                chk("post_rst_done", 32'(done_o), 32'd0);
            end
        end else begin
            chk("beat_count", 32'(beat), 32'(int'(len) + 1));
            step();
            chk("done_pulse", 32'(done_o), 32'd1);
            chk("done_idle", 32'(busy_o), 32'd0);
            chk("done_tvalid", 32'(m_tvalid_o), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        base_addr_i = 8'h00;
        len_i       = 8'h00;
        m_tready_i  = 1'b0;
        repeat (3) step();
        chk("reset_tvalid", 32'(m_tvalid_o), 32'd0);
        chk("reset_tlast", 32'(m_tlast_o), 32'd0);
        chk("reset_tdata", 32'(m_tdata_o), 32'd0);
        chk("reset_addr", 32'(rom_addr_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        rst_i = 1'b0;
        step();

        // Single word
        do_burst(8'h10, 8'd0, 0, 0);
        step();
        chk("done_one_cycle", 32'(done_o), 32'd0);

        // Full rate
        do_burst(8'h00, 8'd15, 0, 0);
        step();
        chk("done_one_cycle", 32'(done_o), 32'd0);

        // Address wrap
        do_burst(8'hFE, 8'd3, 0, 0);
        step();

        // Backpressure, random base
        do_burst(8'($urandom_range(0, 255)), 8'd7, 1, 0);
        step();

        // Stray start ignored, then start in the done cycle accepted
        do_burst(8'h40, 8'd5, 2, 0);
        do_burst(8'h30, 8'd2, 0, 0);
        step();
        chk("done_one_cycle", 32'(done_o), 32'd0);

        // Reset after beat 3, then a clean burst
        m_tready_i = 1'b1;
        do_burst(8'h50, 8'd9, 0, 3);
        do_burst(8'h20, 8'd1, 0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rom_streamer.md
ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning ROM word width and stream data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning ROM address width (depth 2**ADDR_WIDTH).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: request to start a burst; sampled only in IDLE.
REQ-006 The block SHALL have port base_addr_i, input, ADDR_WIDTH bits: first ROM address of the burst.
REQ-007 The block SHALL have port len_i, input, ADDR_WIDTH bits: burst length minus one (0 = 1 word, all-ones = full ROM).
REQ-008 The block SHALL have port rom_addr_o, output, ADDR_WIDTH bits: address to the ROM, which returns data one cycle later.
REQ-009 The block SHALL have port rom_data_i, input, DATA_WIDTH bits: registered ROM read data.
REQ-010 The block SHALL have ports m_tdata_o (DATA_WIDTH), m_tvalid_o (1), m_tlast_o (1), outputs, and m_tready_i (1), input: AXI-Stream-style output.
REQ-011 The block SHALL have ports busy_o and done_o, outputs, 1 bit each: burst in progress; one-cycle pulse on burst completion.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-013 IDLE -> RUN when start_i=1: base_addr_i and len_i are latched; issue address counter = base, issue count = 0.
REQ-014 In RUN, a read is issued in a cycle when (buffered words + in-flight reads - output pop this cycle) < 2; rom_addr_o equals the issue counter in that cycle, which then increments.
REQ-015 Address arithmetic SHALL be modulo 2**ADDR_WIDTH; base + len beyond the top wraps to address 0.
REQ-016 RUN -> DRAIN in the cycle after the (len+1)-th read is issued; no further reads are issued.
REQ-017 Data returned by the ROM one cycle after issue SHALL be written into a 2-entry FIFO; write on a full FIFO SHALL be impossible by REQ-014.
REQ-018 m_tvalid_o = FIFO not empty; m_tdata_o = FIFO head; a pop occurs when m_tvalid_o and m_tready_i are both 1.
REQ-019 m_tdata_o and m_tlast_o SHALL stay stable while m_tvalid_o=1 and m_tready_i=0.
REQ-020 m_tlast_o SHALL be 1 exactly on the (len+1)-th output word.
REQ-021 On the pop of the tlast word: done_o = 1 in the next cycle for one cycle, FSM -> IDLE.
REQ-022 Latency: start_i sampled at edge N -> first rom_addr_o in cycle N+1 -> first m_tvalid_o in cycle N+3.
REQ-023 With m_tready_i held 1, throughput SHALL be one word per cycle with no gaps after the first word.
REQ-024 busy_o = 1 in RUN and DRAIN, 0 in IDLE; start_i while busy_o=1 SHALL be ignored.
REQ-025 start_i in the cycle done_o is high SHALL be accepted (FSM already in IDLE).
REQ-026 When idle, rom_addr_o SHALL hold its last value; the ROM read it causes is ignored.

Reset
REQ-027 On rst_i=1 at a clock edge, the FSM SHALL go to IDLE, the FIFO SHALL be emptied, in-flight reads SHALL be discarded and counters SHALL be zeroed.
REQ-028 Reset values SHALL be: m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, rom_addr_o=0, busy_o=0, done_o=0.
REQ-029 A reset mid-burst SHALL produce no further output words and no done_o pulse.

Structure
REQ-030 Package rom_streamer_pkg SHALL hold the FSM state typedef (IDLE, RUN, DRAIN) and the FIFO depth constant (2).
REQ-031 The 2-entry FIFO SHALL be a sub-module, skid_fifo, parameterised by DATA_WIDTH, with a count output.
REQ-032 The implementation SHALL connect directly to the existing rom module (one-cycle registered read) without glue logic.

Verification
REQ-033 Single word: ROM[i]=i^8'hA5, base=0x10, len=0, tready=1 -> one beat with data 0xB5 and tlast=1 at cycle N+3; done_o at N+4.
REQ-034 Full rate: base=0x00, len=15, tready=1 -> 16 consecutive beats with data ROM[0..15] and tlast only on beat 16.
REQ-035 Wrap: base=0xFE, len=3 -> data ROM[0xFE], ROM[0xFF], ROM[0x00], ROM[0x01].
REQ-036 Backpressure: len=7 with tready toggled randomly (including 5 cycles low) -> all 8 words in order, no loss or duplication, data stable while stalled.
REQ-037 Reset mid-burst: rst_i=1 after beat 3 of len=9 -> m_tvalid_o=0 next cycle, busy_o=0, no done_o; a new burst with base=0x20, len=1 then completes normally.
REQ-038 Ignored start: start_i pulsed during a busy burst -> the burst is unchanged; start_i in the done_o cycle -> the new burst begins.
